y86_regfile_dbg: RTL and testbench

Parametrised register file for the sequential Y86 CPU. It has two combinational read ports (srcA/srcB) and two write ports (dstE/valE, dstM/valM) with Y86 write-priority and write-through bypass. A built-in debug dump FSM streams every register out over a valid-qualified port, so benches read architectural state through the port instead of probing hierarchy. It sits between decode (reads) and write-back (writes) in cpu_top.

---
 rtl/y86_pkg.sv | 39 +++
 rtl/y86_regfile_dbg_if.sv | 37 +++
 rtl/regfile_dump_fsm.sv | 98 +++++++++
 rtl/y86_regfile_dbg.sv | 105 ++++++++++
 tb/tb_y86_regfile_dbg.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// -----------------------------------------------------------------------------
// y86_pkg
// Shared definitions for the Y86 register file and its debug dump engine:
// default geometry, the "no register" index, architectural register numbers
// and the dump FSM state encoding.
// -----------------------------------------------------------------------------
package y86_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int NREGS_DEF  = 15;
    localparam int ADDR_W_DEF = 4;

    // Index meaning "no register": reads return 0, writes are dropped.
    localparam logic [3:0] RNONE = 4'hF;

    // Architectural register numbers.
    localparam logic [3:0] RRAX = 4'h0;
    localparam logic [3:0] RRCX = 4'h1;
    localparam logic [3:0] RRDX = 4'h2;
    localparam logic [3:0] RRBX = 4'h3;
    localparam logic [3:0] RRSP = 4'h4;
    localparam logic [3:0] RRBP = 4'h5;
    localparam logic [3:0] RRSI = 4'h6;
    localparam logic [3:0] RRDI = 4'h7;
    localparam logic [3:0] RR8  = 4'h8;
    localparam logic [3:0] RR9  = 4'h9;
    localparam logic [3:0] RR10 = 4'hA;
    localparam logic [3:0] RR11 = 4'hB;
    localparam logic [3:0] RR12 = 4'hC;
    localparam logic [3:0] RR13 = 4'hD;
    localparam logic [3:0] RR14 = 4'hE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } dump_state_e;

endpackage

// File: rtl/y86_regfile_dbg_if.sv
// -----------------------------------------------------------------------------
// y86_regfile_dbg_if
// Bundles the register file's read, write-back and debug-dump signals.
//   master : driven by decode/write-back (or a bench): srcA/srcB, wr_en,
//            dstE/valE, dstM/valM, dbg_start; observes valA/valB and dbg_*.
//   slave  : the register file itself.
// -----------------------------------------------------------------------------
interface y86_regfile_dbg_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] srcA;
    logic [ADDR_W-1:0] srcB;
    logic [DATA_W-1:0] valA;
    logic [DATA_W-1:0] valB;
    logic              wr_en;
    logic [ADDR_W-1:0] dstE;
    logic [DATA_W-1:0] valE;
    logic [ADDR_W-1:0] dstM;
    logic [DATA_W-1:0] valM;
    logic              dbg_start;
    logic              dbg_busy;
    logic              dbg_valid;
    logic [ADDR_W-1:0] dbg_idx;
    logic [DATA_W-1:0] dbg_data;
    logic              dbg_done;

    modport master (
        output srcA, srcB, wr_en, dstE, valE, dstM, valM, dbg_start,
        input  valA, valB, dbg_busy, dbg_valid, dbg_idx, dbg_data, dbg_done
    );

    modport slave (
        input  srcA, srcB, wr_en, dstE, valE, dstM, valM, dbg_start,
        output valA, valB, dbg_busy, dbg_valid, dbg_idx, dbg_data, dbg_done
    );
endinterface

// File: rtl/regfile_dump_fsm.sv
// -----------------------------------------------------------------------------
// regfile_dump_fsm
// Walks register indices 0..NREGS-1, presenting one register per cycle on a
// valid-qualified port, then pulses done for one cycle.
//   clk, reset  : clock, asynchronous active-low reset
//   start       : dump request (ignored while busy)
//   rd_idx      : index into the register array being read
//   rd_data     : array contents at rd_idx (raw, no bypass)
//   busy        : high in DUMP and DONE
//   valid/idx/data : current dump beat; idx/data are 0 when not valid
//   done        : one-cycle pulse after the last beat
// -----------------------------------------------------------------------------
module regfile_dump_fsm
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 15,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_idx,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              valid,
    output logic [ADDR_W-1:0] idx,
    output logic [DATA_W-1:0] data,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    dump_state_e       state_r;
    dump_state_e       state_nxt_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_nxt_s;

    // State and beat counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic and dump port outputs; all outputs decode registered state.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        busy        = 1'b0;
        valid       = 1'b0;
        done        = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_nxt_s = '0;
                if (start) begin
                    state_nxt_s = DUMP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DUMP: begin
                busy  = 1'b1;
                valid = 1'b1;
                if (cnt_r == LAST_IDX) begin
                    state_nxt_s = DONE;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s   = cnt_r + ADDR_W'(1);
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
        // Idle beats present zeros rather than stale counter/array contents.
        if (valid) begin
            idx  = cnt_r;
            data = rd_data;
        end else begin
            idx  = '0;
            data = '0;
        end
    end

    assign rd_idx = cnt_r;

endmodule

// File: rtl/y86_regfile_dbg.sv
// -----------------------------------------------------------------------------
// y86_regfile_dbg
// Y86 register file: two combinational read ports with write-through bypass
// (M beats E), two write ports (M wins when both target the same register),
// plus a debug dump engine streaming every register out.
//   clk, reset : clock, asynchronous active-low reset
//   rf         : y86_regfile_dbg_if slave (reads, write-back, dbg_*)
// -----------------------------------------------------------------------------
module y86_regfile_dbg
    import y86_pkg::*;
#(
    parameter int                DATA_W = DATA_W_DEF,
    parameter int                NREGS  = NREGS_DEF,
    parameter int                ADDR_W = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RNONE  = ADDR_W'(y86_pkg::RNONE)
) (
    input  logic               clk,
    input  logic               reset,
    y86_regfile_dbg_if.slave   rf
);

    logic [DATA_W-1:0] regs_r [NREGS];
    logic [ADDR_W-1:0] src_s  [2];
    logic [DATA_W-1:0] val_s  [2];
    logic              e_ok_s;
    logic              m_ok_s;
    logic [ADDR_W-1:0] dump_idx_s;
    logic [DATA_W-1:0] dump_data_s;

    // True for an index that names a real architectural register.
    function automatic logic idx_ok(input logic [ADDR_W-1:0] i);
        return (i != RNONE) && (i < ADDR_W'(NREGS));
    endfunction

    assign e_ok_s   = rf.wr_en && idx_ok(rf.dstE);
    assign m_ok_s   = rf.wr_en && idx_ok(rf.dstM);
    assign src_s[0] = rf.srcA;
    assign src_s[1] = rf.srcB;

    // Register array; M is checked first so dstE==dstM keeps only valM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (m_ok_s && (rf.dstM == ADDR_W'(i))) begin
                    regs_r[i] <= rf.valM;
                end else if (e_ok_s && (rf.dstE == ADDR_W'(i))) begin
                    regs_r[i] <= rf.valE;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Read ports with write-through bypass, M taking priority over E.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            val_s[p] = '0;
            if (!idx_ok(src_s[p])) begin
                val_s[p] = '0;
            end else if (m_ok_s && (src_s[p] == rf.dstM)) begin
                val_s[p] = rf.valM;
            end else if (e_ok_s && (src_s[p] == rf.dstE)) begin
                val_s[p] = rf.valE;
            end else begin
                val_s[p] = regs_r[src_s[p]];
            end
        end
    end

    assign rf.valA = val_s[0];
    assign rf.valB = val_s[1];

    // Dump port sees raw array contents: same-cycle writes are not bypassed.
    always_comb begin
        dump_data_s = '0;
        if (dump_idx_s < ADDR_W'(NREGS)) begin
            dump_data_s = regs_r[dump_idx_s];
        end else begin
            dump_data_s = '0;
        end
    end

    regfile_dump_fsm #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_dump (
        .clk     (clk),
        .reset   (reset),
        .start   (rf.dbg_start),
        .rd_idx  (dump_idx_s),
        .rd_data (dump_data_s),
        .busy    (rf.dbg_busy),
        .valid   (rf.dbg_valid),
        .idx     (rf.dbg_idx),
        .data    (rf.dbg_data),
        .done    (rf.dbg_done)
    );

endmodule

// File: tb/tb_y86_regfile_dbg.sv
// -----------------------------------------------------------------------------
// tb_y86_regfile_dbg
// Directed self-checking bench for y86_regfile_dbg. A reference array tracks
// architectural state; dump beats are queued when a dump is requested and
// popped as the DUT presents them.
// -----------------------------------------------------------------------------
module tb_y86_regfile_dbg;

    localparam logic [3:0] RN = 4'hF;

    typedef struct packed {
        logic [3:0]  idx;
        logic [63:0] data;
    } beat_t;

    logic clk;
    logic reset;

    y86_regfile_dbg_if #(.DATA_W(64), .ADDR_W(4)) rf ();

    y86_regfile_dbg dut (
        .clk   (clk),
        .reset (reset),
        .rf    (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] model [15];
    beat_t       sb [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_rd(input int i);
        return (i < 15) ? model[i] : 64'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read every index on both ports (A ascending, B descending) with no write.
    task automatic read_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            rf.srcA = 4'(i);
            rf.srcB = 4'(15 - i);
            #1;
            check($sformatf("%s_A%0d", tag, i), rf.valA, model_rd(i));
            check($sformatf("%s_B%0d", tag, 15 - i), rf.valB, model_rd(15 - i));
        end
    endtask

    // One write-back cycle; the reference follows Y86 rules independently.
    task automatic write2(input logic [3:0] de, input logic [63:0] ve,
                          input logic [3:0] dm, input logic [63:0] vm);
        rf.wr_en = 1'b1;
        rf.dstE  = de;
        rf.valE  = ve;
        rf.dstM  = dm;
        rf.valM  = vm;
        tick();
        rf.wr_en = 1'b0;
        rf.dstE  = RN;
        rf.dstM  = RN;
        if (de < 4'd15 && de != dm) model[de] = ve;
        if (dm < 4'd15) model[dm] = vm;
    endtask

    task automatic push_dump();
        sb.delete();
        for (int i = 0; i < 15; i++) begin
            sb.push_back('{idx: 4'(i), data: model[i]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;
        int    beats;
        int    got_done;
        int    reset_hit;
        int    saw10;
        int    done_seen;

        for (int i = 0; i < 15; i++) model[i] = 64'h0;
        reset        = 1'b0;
        rf.srcA      = 4'h0;
        rf.srcB      = 4'h0;
        rf.wr_en     = 1'b0;
        rf.dstE      = RN;
        rf.valE      = 64'h0;
        rf.dstM      = RN;
        rf.valM      = 64'h0;
        rf.dbg_start = 1'b0;

        // Reset state of the dump port.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  64'(rf.dbg_busy),  64'h0);
        check("rst_valid", 64'(rf.dbg_valid), 64'h0);
        check("rst_done",  64'(rf.dbg_done),  64'h0);
        check("rst_idx",   64'(rf.dbg_idx),   64'h0);
        check("rst_data",  rf.dbg_data,       64'h0);
        reset = 1'b1;
        tick();
        read_all("init");

        // E write with same-cycle bypass, then from the array.
        tick();
        rf.wr_en = 1'b1; rf.dstE = 4'd3; rf.valE = 64'h1234; rf.dstM = RN; rf.srcA = 4'd3;
        #1;
        check("bypE_valA", rf.valA, 64'h1234);
        tick();
        rf.wr_en = 1'b0; model[3] = 64'h1234;
        #1;
        check("arr_r3", rf.valA, 64'h1234);

        // Same destination on both ports: M wins for bypass and write.
        rf.wr_en = 1'b1; rf.dstE = 4'd4; rf.valE = 64'hAA; rf.dstM = 4'd4; rf.valM = 64'hBB;
        rf.srcA = 4'd4; rf.srcB = 4'd4;
        #1;
        check("bypM_valA", rf.valA, 64'hBB);
        check("bypM_valB", rf.valB, 64'hBB);
        tick();
        rf.wr_en = 1'b0; model[4] = 64'hBB;
        #1;
        check("arr_r4", rf.valA, 64'hBB);

        // Different destinations: each port bypasses its own value.
        rf.wr_en = 1'b1; rf.dstE = 4'd5; rf.valE = 64'h5555; rf.dstM = 4'd6; rf.valM = 64'h6666;
        rf.srcA = 4'd5; rf.srcB = 4'd6;
        #1;
        check("bypE5_valA", rf.valA, 64'h5555);
        check("bypM6_valB", rf.valB, 64'h6666);
        tick();
        rf.wr_en = 1'b0; model[5] = 64'h5555; model[6] = 64'h6666;

        // Dropped writes to RNONE / index 15.
        rf.wr_en = 1'b1; rf.dstE = RN; rf.valE = 64'hDEAD; rf.dstM = 4'd15; rf.valM = 64'hBEEF;
        rf.srcA = 4'd15; rf.srcB = 4'd3;
        #1;
        check("rnone_valA", rf.valA, 64'h0);
        check("rnone_valB", rf.valB, 64'h1234);
        tick();
        rf.wr_en = 1'b0; rf.dstM = RN;
        read_all("after_drop");

        // Full-width data and dump preload.
        write2(4'd7, 64'hFEDC_BA98_7654_3210, RN, 64'h0);
        write2(4'd1, 64'h1, 4'd2, 64'h2);
        write2(4'd8, 64'h8, 4'd14, 64'hE);
        read_all("preload");

        // Full dump with an ignored second start mid-dump.
        tick();
        rf.dbg_start = 1'b1;
        push_dump();
        beats = 0; got_done = 0;
        for (int c = 0; c < 40 && got_done == 0; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                rf.dbg_start = 1'b0;
                check("dump_first_valid", 64'(rf.dbg_valid), 64'h1);
                check("dump_busy",        64'(rf.dbg_busy),  64'h1);
            end
            if (c == 3) rf.dbg_start = 1'b1;
            if (c == 4) rf.dbg_start = 1'b0;
            if (rf.dbg_valid) begin
                beats++;
                if (sb.size() > 0) begin
                    b = sb.pop_front();
                    check($sformatf("dump_idx%0d", b.idx), 64'(rf.dbg_idx), 64'(b.idx));
                    check($sformatf("dump_data%0d", b.idx), rf.dbg_data, b.data);
                end
            end else if (rf.dbg_done) begin
                got_done = 1;
                check("done_idx",  64'(rf.dbg_idx),  64'h0);
                check("done_data", rf.dbg_data,      64'h0);
                check("done_busy", 64'(rf.dbg_busy), 64'h1);
            end
        end
        check("dump_done_seen", 64'(got_done),  64'h1);
        check("dump_beats",     64'(beats),     64'd15);
        check("dump_sb_empty",  64'(sb.size()), 64'h0);
        tick();
        check("post_busy",  64'(rf.dbg_busy),  64'h0);
        check("post_valid", 64'(rf.dbg_valid), 64'h0);
        check("post_done",  64'(rf.dbg_done),  64'h0);
        tick();
        check("no_requeue_busy", 64'(rf.dbg_busy), 64'h0);

        // Dump aborted by reset after a mid-dump write.
        rf.dbg_start = 1'b1;
        push_dump();
        reset_hit = 0; done_seen = 0; saw10 = 0;
        for (int c = 0; c < 40 && reset_hit == 0; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) rf.dbg_start = 1'b0;
            rf.wr_en = 1'b0;
            rf.dstE  = RN;
            if (rf.dbg_done) done_seen = 1;
            if (rf.dbg_valid) begin
                if (sb.size() > 0) begin
                    b = sb.pop_front();
                    check($sformatf("abort_idx%0d", b.idx), 64'(rf.dbg_idx), 64'(b.idx));
                    check($sformatf("abort_data%0d", b.idx), rf.dbg_data, b.data);
                end
                if (rf.dbg_idx == 4'd5) begin
                    rf.wr_en = 1'b1; rf.dstE = 4'd10; rf.valE = 64'h55;
                    model[10] = 64'h55;
                    foreach (sb[k]) if (sb[k].idx == 4'd10) sb[k].data = 64'h55;
                end
                if (rf.dbg_idx == 4'd9) begin
                    rf.srcA = 4'd10;
                    #1;
                    check("mid_dump_r10", rf.valA, 64'h55);
                    rf.srcA = 4'd1;
                    #1;
                    check("pre_reset_r1", rf.valA, 64'h1);
                    reset = 1'b0;
                    #1;
                    reset_hit = 1;
                    check("async_r1", rf.valA, 64'h0);
                end
            end
        end
        check("abort_reset_hit", 64'(reset_hit), 64'h1);
        check("abort_valid", 64'(rf.dbg_valid), 64'h0);
        check("abort_busy",  64'(rf.dbg_busy),  64'h0);
        for (int i = 0; i < 15; i++) model[i] = 64'h0;
        sb.delete();
        read_all("in_reset");
        tick();
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (rf.dbg_valid && rf.dbg_idx == 4'd10) saw10 = 1;
            if (rf.dbg_done) done_seen = 1;
        end
        check("abort_no_idx10", 64'(saw10),     64'h0);
        check("abort_no_done",  64'(done_seen), 64'h0);
        read_all("after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
